con_loader: RTL and testbench

Synchronous loader that streams 32-bit words into the core's data memory through the console port (`con_write`/`con_addr`/`con_in`), with optional per-word read-back verification via `con_out`. It is the writer side of the console port, whose read side is the post-run memory dump. It sits between a host-side word stream (UART bridge or bench driver) and the `core` console port. It runs only while the core is held idle.

---
 rtl/con_loader_pkg.sv | 20 ++
 rtl/con_loader_con_readback.sv | 29 ++
 rtl/con_loader.sv | 176 +++++++++++++++++
 tb/tb_con_loader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/con_loader_pkg.sv
// con_loader_pkg: console-port constants shared by the loader and its
// read-back strobe, plus the loader state encoding.
package con_loader_pkg;

    localparam int CON_DATA_W = 32;
    localparam int CON_WE_W   = 4;

    localparam logic [CON_WE_W-1:0] CL_WE_ALL  = 4'hF;
    localparam logic [CON_WE_W-1:0] CL_WE_NONE = 4'h0;

    typedef enum logic [2:0] {
        CL_IDLE,
        CL_ACCEPT,
        CL_WRITE,
        CL_READ,
        CL_CMP,
        CL_FIN
    } cl_state_t;

endpackage

// File: rtl/con_loader_con_readback.sv
// con_readback: delays the write strobe by READ_LAT cycles so the loader
// knows when con_out reflects the word it just wrote.
module con_readback
    import con_loader_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic CLK,
    input  logic rst,
    input  logic wr_stb,
    output logic cmp_stb
);

    logic [READ_LAT-1:0] sr_q;
    logic [READ_LAT:0]   sr_d;

    assign sr_d    = {sr_q, wr_stb};
    assign cmp_stb = sr_q[READ_LAT-1];

    // Shift the write strobe through the read-latency pipe.
    always_ff @(posedge CLK) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d[READ_LAT-1:0];
        end
    end

endmodule

// File: rtl/con_loader.sv
// con_loader: streams host words into data memory over the console
// port, optionally reading each one back and flagging the first mismatch.
`ifndef DATAMEM_BITS
`define DATAMEM_BITS 9
`endif

module con_loader
    import con_loader_pkg::*;
#(
    parameter int DATAMEM_BITS = `DATAMEM_BITS,
    parameter int READ_LAT     = 1
) (
    input  logic                      CLK,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DATAMEM_BITS:0]     base_addr,
    input  logic                      verify_en,
    input  logic                      s_valid,
    input  logic [CON_DATA_W-1:0]     s_data,
    input  logic                      s_last,
    output logic                      s_ready,
    output logic [CON_WE_W-1:0]       con_write,
    output logic [DATAMEM_BITS:0]     con_addr,
    output logic [CON_DATA_W-1:0]     con_in,
    input  logic [CON_DATA_W-1:0]     con_out,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [DATAMEM_BITS:0]     err_addr,
    output logic [DATAMEM_BITS+1:0]   word_count
);

    localparam int AW = DATAMEM_BITS + 1;
    localparam int CW = DATAMEM_BITS + 2;
    localparam logic [AW-1:0] ADDR_MAX = '1;

    cl_state_t             state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [AW-1:0]         caddr_q, caddr_d;
    logic [CON_DATA_W-1:0] data_q, data_d;
    logic                  last_q, last_d;
    logic                  ver_q, ver_d;
    logic                  err_q, err_d;
    logic [AW-1:0]         eaddr_q, eaddr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  adv;
    logic                  wr_stb;
    logic                  cmp_stb;

    assign con_addr   = caddr_q;
    assign con_in     = data_q;
    assign err        = err_q;
    assign err_addr   = eaddr_q;
    assign word_count = cnt_q;
    assign wr_stb     = (state_q == CL_WRITE) && ver_q;

    con_readback #(
        .READ_LAT (READ_LAT)
    ) u_readback (
        .CLK     (CLK),
        .rst     (rst),
        .wr_stb  (wr_stb),
        .cmp_stb (cmp_stb)
    );

    // State and datapath registers; reset clears every visible output.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= CL_IDLE;
            addr_q  <= '0;
            caddr_q <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            ver_q   <= 1'b0;
            err_q   <= 1'b0;
            eaddr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            caddr_q <= caddr_d;
            data_q  <= data_d;
            last_q  <= last_d;
            ver_q   <= ver_d;
            err_q   <= err_d;
            eaddr_q <= eaddr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, datapath updates and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        caddr_d   = caddr_q;
        data_d    = data_q;
        last_d    = last_q;
        ver_d     = ver_q;
        err_d     = err_q;
        eaddr_d   = eaddr_q;
        cnt_d     = cnt_q;
        adv       = 1'b0;
        s_ready   = 1'b0;
        con_write = CL_WE_NONE;
        done      = 1'b0;
        busy      = (state_q != CL_IDLE);

        unique case (state_q)
            CL_IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    ver_d   = verify_en;
                    err_d   = 1'b0;
                    eaddr_d = '0;
                    cnt_d   = '0;
                    state_d = CL_ACCEPT;
                end
            end
            CL_ACCEPT: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    data_d  = s_data;
                    last_d  = s_last;
                    caddr_d = addr_q;
                    state_d = CL_WRITE;
                end
            end
            CL_WRITE: begin
                con_write = CL_WE_ALL;
                cnt_d     = cnt_q + CW'(1);
                if (ver_q) begin
                    state_d = CL_READ;
                end else begin
                    adv = 1'b1;
                end
            end
            CL_READ: begin
                if (cmp_stb) begin
                    state_d = CL_CMP;
                end
            end
            CL_CMP: begin
                if ((con_out != data_q) && !err_q) begin
                    err_d   = 1'b1;
                    eaddr_d = addr_q;
                end
                adv = 1'b1;
            end
            CL_FIN: begin
                done    = 1'b1;
                state_d = CL_IDLE;
            end
            default: begin
                state_d = CL_IDLE;
            end
        endcase

        // Running off the top of memory ends the transfer with an error
        // rather than wrapping onto words already loaded.
        if (adv) begin
            if (last_q) begin
                state_d = CL_FIN;
            end else if (addr_q == ADDR_MAX) begin
                if (!err_d) begin
                    eaddr_d = ADDR_MAX;
                end
                err_d   = 1'b1;
                state_d = CL_FIN;
            end else begin
                addr_d  = addr_q + AW'(1);
                state_d = CL_ACCEPT;
            end
        end
    end

endmodule

// File: tb/tb_con_loader.sv
// tb_con_loader: directed and random transfers checked against a
// word-level model of the loader and a behavioural data memory.
module tb_con_loader;

    localparam int DB = 9;
    localparam int AW = DB + 1;
    localparam int RL = 1;
    localparam logic [AW-1:0] AMAX = '1;

    logic          CLK = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          verify_en = 1'b0;
    logic          s_valid = 1'b0;
    logic [31:0]   s_data = '0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [3:0]    con_write;
    logic [AW-1:0] con_addr;
    logic [31:0]   con_in;
    logic [31:0]   con_out;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] err_addr;
    logic [AW:0]   word_count;

    con_loader #(
        .DATAMEM_BITS (DB),
        .READ_LAT     (RL)
    ) dut (
        .CLK        (CLK),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .verify_en  (verify_en),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .con_write  (con_write),
        .con_addr   (con_addr),
        .con_in     (con_in),
        .con_out    (con_out),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_addr   (err_addr),
        .word_count (word_count)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Data memory with one-cycle read latency and an optional bad cell.
    logic [31:0]   mem [0:(1<<AW)-1];
    logic [31:0]   rd_q = '0;
    logic          bad_en = 1'b0;
    logic [AW-1:0] bad_addr = '0;
    int            cyc = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            acc_q[$];
    logic [45:0]   wr_q[$];

    assign con_out = rd_q;

    // Memory, write log, handshake log and done-pulse log.
    always @(posedge CLK) begin
        for (int b = 0; b < 4; b++) begin
            if (con_write[b]) mem[con_addr][8*b +: 8] <= con_in[8*b +: 8];
        end
        if (con_write != 4'h0) wr_q.push_back({con_write, con_addr, con_in});
        if (bad_en && con_addr == bad_addr) rd_q <= 32'hDEAD_BEEF;
        else rd_q <= mem[con_addr];
        if (s_valid && s_ready) acc_q.push_back(cyc);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        cyc++;
    end

    task automatic check_zero(input string p);
        check({p, "_s_ready"}, s_ready, 0);
        check({p, "_con_write"}, con_write, 0);
        check({p, "_con_addr"}, con_addr, 0);
        check({p, "_con_in"}, con_in, 0);
        check({p, "_busy"}, busy, 0);
        check({p, "_done"}, done, 0);
        check({p, "_err"}, err, 0);
        check({p, "_err_addr"}, err_addr, 0);
        check({p, "_word_count"}, word_count, 0);
    endtask

    logic [31:0] w[$];
    int          gaps[$];

    task automatic xfer(input logic [AW-1:0] base, input bit ver, input bit tp);
        int            n;
        logic [AW-1:0] e_addr[$];
        logic [31:0]   e_data[$];
        bit            e_err;
        logic [AW-1:0] e_eaddr;
        bit            wrap;
        int            d0;
        int            a0;
        int            tmo;
        bit            stop;
        bit            gap_ok;
        logic [AW-1:0] a;
        n = w.size();
        e_err = 0;
        e_eaddr = '0;
        wrap = 0;
        stop = 0;
        gap_ok = 1;
        // Reference: walk the stream one word at a time.
        for (int i = 0; i < n && !wrap; i++) begin
            a = AW'(int'(base) + i);
            e_addr.push_back(a);
            e_data.push_back(w[i]);
            if (ver && bad_en && a == bad_addr && w[i] != 32'hDEAD_BEEF && !e_err) begin
                e_err = 1;
                e_eaddr = a;
            end
            if (a == AMAX && i != n - 1) begin
                wrap = 1;
                if (!e_err) e_eaddr = AMAX;
                e_err = 1;
            end
        end

        acc_q.delete();
        wr_q.delete();
        d0 = done_cnt;
        @(negedge CLK);
        start = 1;
        base_addr = base;
        verify_en = ver;
        @(negedge CLK);
        start = 0;
        base_addr = '0;
        verify_en = 0;
        check("busy_rise", busy, 1);
        check("cnt_clear", word_count, 0);
        for (int i = 0; i < n && !stop; i++) begin
            s_valid = 0;
            s_last = 0;
            for (int g = 0; g < gaps[i]; g++) begin
                if (g > 0 && !ver) gap_ok &= (s_ready === 1'b1 && con_write === 4'h0);
                @(negedge CLK);
            end
            s_valid = 1;
            s_data = w[i];
            s_last = (i == n - 1);
            a0 = acc_q.size();
            tmo = 0;
            while (acc_q.size() == a0 && done_cnt == d0 && tmo < 50) begin
                @(negedge CLK);
                tmo++;
            end
            if (acc_q.size() == a0) stop = 1;
        end
        s_valid = 0;
        s_last = 0;
        tmo = 0;
        while (done_cnt == d0 && tmo < 80) begin
            @(negedge CLK);
            tmo++;
        end
        @(negedge CLK);
        check("done_once", done_cnt - d0, 1);
        check("busy_fall", busy, 0);
        check("done_low", done, 0);
        check("accepts", acc_q.size(), e_addr.size());
        if (acc_q.size() > 0)
            check("done_lat", done_cyc - acc_q[acc_q.size()-1], ver ? 3 + RL : 2);
        if (tp)
            for (int i = 1; i < acc_q.size(); i++)
                check("word_cycles", acc_q[i] - acc_q[i-1], ver ? 3 + RL : 2);
        check("gap_quiet", gap_ok, 1);
        check("writes", wr_q.size(), e_addr.size());
        for (int i = 0; i < e_addr.size() && i < wr_q.size(); i++) begin
            check("wr_we", wr_q[i][45:42], 4'hF);
            check("wr_addr", wr_q[i][41:32], e_addr[i]);
            check("wr_data", wr_q[i][31:0], e_data[i]);
            check("mem", mem[e_addr[i]], e_data[i]);
        end
        check("word_count", word_count, e_addr.size());
        check("err", err, e_err);
        check("err_addr", err_addr, e_eaddr);
    endtask

    int            rn;
    logic [AW-1:0] rb;
    bit            rv;
    bit            rtp;

    initial begin
        rst = 1;
        repeat (3) @(negedge CLK);
        check_zero("rst");
        rst = 0;
        @(negedge CLK);
        check_zero("idle");

        w = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        gaps = '{0, 0, 0, 0};
        xfer(10'h010, 0, 1);
        xfer(10'h010, 1, 1);
        bad_en = 1;
        bad_addr = 10'h012;
        xfer(10'h010, 1, 1);
        bad_en = 0;
        gaps = '{0, 0, 7, 0};
        xfer(10'h010, 0, 0);

        w = '{32'h1111_2222, 32'h3333_4444};
        gaps = '{0, 0};
        xfer(AMAX, 0, 1);
        xfer(AMAX, 1, 1);

        w = '{32'h5555_0001, 32'h5555_0002};
        @(negedge CLK);
        start = 1;
        base_addr = 10'h020;
        verify_en = 1;
        @(negedge CLK);
        start = 0;
        verify_en = 0;
        base_addr = '0;
        s_valid = 1;
        s_data = w[0];
        @(negedge CLK);
        s_valid = 0;
        @(negedge CLK);
        check("mid_busy", busy, 1);
        check("mid_we", con_write, 0);
        check("mid_addr", con_addr, 10'h020);
        rst = 1;
        start = 1;
        @(negedge CLK);
        check_zero("midrst");
        rst = 0;
        start = 0;
        @(negedge CLK);
        check("rst_start_ignored", busy, 0);
        check("kept_write", mem[10'h020], 32'h5555_0001);
        xfer(10'h020, 1, 1);

        for (int t = 0; t < 12; t++) begin
            rn = $urandom_range(1, 6);
            if (t % 4 == 0) rb = AMAX - AW'($urandom_range(0, 2));
            else rb = AW'($urandom_range(0, 1023));
            rv = 1'($urandom_range(0, 1));
            rtp = 1;
            w.delete();
            gaps.delete();
            for (int i = 0; i < rn; i++) begin
                w.push_back($urandom);
                if ($urandom_range(0, 3) == 0) begin
                    gaps.push_back($urandom_range(1, 4));
                    rtp = 0;
                end else begin
                    gaps.push_back(0);
                end
            end
            bad_en = 1'($urandom_range(0, 1));
            bad_addr = rb + AW'($urandom_range(0, rn - 1));
            xfer(rb, rv, rtp);
        end
        bad_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
